// File: rtl/pixel_unpack_rgb.sv
// Streaming unpacker: 32-bit packed pixel words in, one (R,G,B) pixel per beat out.
// Handles RGB888/XRGB8888 (1 px/word) and RGB565/RGB444 (2 px/word, low half first).
module pixel_unpack_rgb #(
  parameter int unsigned CW        = 8,
  parameter bit          REPLICATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    fmt,
  input  logic          bgr_swap,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CW-1:0] out_r,
  output logic [CW-1:0] out_g,
  output logic [CW-1:0] out_b,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {EMPTY, P0, P1} state_t;

  state_t          state_q, state_d;
  logic [15:0]     hi_q, hi_d;
  logic [1:0]      fmt_q, fmt_d;
  logic            swap_q, swap_d;
  logic            last_q, last_d;
  logic [3*CW-1:0] pix_q, pix_d;
  logic            olast_q, olast_d;

  logic accept, consume, two_px_q, two_px_in;

  // Left-justify the n-bit field, then OR in copies shifted by n and 2n;
  // n >= 4 and CW <= 12 so three copies always cover the output width.
  function automatic logic [CW-1:0] expand(input logic [7:0] f, input int unsigned n);
    logic [11:0] lj, rep;
    lj  = {4'b0, f} << (12 - n);
    rep = REPLICATE ? (lj | (lj >> n) | (lj >> (2 * n))) : lj;
    return rep[11 -: CW];
  endfunction

  function automatic logic [3*CW-1:0] unpack(input logic [23:0] d, input logic [1:0] f,
                                             input logic sw);
    logic [CW-1:0] r, g, b;
    case (f)
      2'd1: begin
        r = expand({3'b0, d[15:11]}, 5);
        g = expand({2'b0, d[10:5]}, 6);
        b = expand({3'b0, d[4:0]}, 5);
      end
      2'd2: begin
        r = expand({4'b0, d[11:8]}, 4);
        g = expand({4'b0, d[7:4]}, 4);
        b = expand({4'b0, d[3:0]}, 4);
      end
      default: begin
        r = expand(d[23:16], 8);
        g = expand(d[15:8], 8);
        b = expand(d[7:0], 8);
      end
    endcase
    return sw ? {b, g, r} : {r, g, b};
  endfunction

  assign two_px_q  = fmt_q[1] ^ fmt_q[0];
  assign two_px_in = fmt[1] ^ fmt[0];

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = ~rst & ((state_q == EMPTY) |
                             (out_ready & (state_q == P0) & ~two_px_q) |
                             (out_ready & (state_q == P1)));
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    fmt_d   = fmt_q;
    swap_d  = swap_q;
    last_d  = last_q;
    pix_d   = pix_q;
    olast_d = olast_q;
    if (accept) begin
      state_d = P0;
      hi_d    = in_data[31:16];
      fmt_d   = fmt;
      swap_d  = bgr_swap;
      last_d  = in_last;
      pix_d   = unpack(in_data[23:0], fmt, bgr_swap);
      olast_d = in_last & ~two_px_in;
    end else if (consume) begin
      if ((state_q == P0) && two_px_q) begin
        state_d = P1;
        pix_d   = unpack({8'b0, hi_q}, fmt_q, swap_q);
        olast_d = last_q;
      end else begin
        state_d = EMPTY;
        olast_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      hi_q    <= '0;
      fmt_q   <= '0;
      swap_q  <= 1'b0;
      last_q  <= 1'b0;
      pix_q   <= '0;
      olast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      fmt_q   <= fmt_d;
      swap_q  <= swap_d;
      last_q  <= last_d;
      pix_q   <= pix_d;
      olast_q <= olast_d;
    end
  end

  assign out_r    = pix_q[3*CW-1 -: CW];
  assign out_g    = pix_q[2*CW-1 -: CW];
  assign out_b    = pix_q[CW-1:0];
  assign out_last = olast_q;

endmodule
